// File: rtl/i2s_rx_pkg.sv
// Shared constants and helpers for the I2S stereo receiver.
//   SLOT_BITS  : sck periods per channel slot
//   FRAME_BITS : sck periods per stereo frame
//   BIT_CNT_W  : width of the frame bit counter
//   slot_e     : word-select encoding (0 = left, 1 = right)
//   sat_signed : clamps a signed value to the range of a given bit width
package i2s_rx_pkg;

  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned    width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S master timing: clock divider, bit clock, word select and frame bit counter.
//   clk, reset : system clock, synchronous active-high reset
//   sck        : registered bit clock, toggles every CLK_DIV/2 clk cycles
//   ws         : registered word select, (b >= 32), updated on sck falls
//   bit_cnt    : frame bit counter b (0..63), advances on sck falls
//   rise_stb   : high in the clk cycle whose closing edge drives sck 0->1
//   fall_stb   : high in the clk cycle whose closing edge drives sck 1->0
module i2s_clk_gen
  import i2s_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 sck,
  output logic                 ws,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 rise_stb,
  output logic                 fall_stb
);

  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic                 half_done;
  logic [BIT_CNT_W-1:0] bit_next;

  always_comb begin
    half_done = (div_cnt == DIV_LAST);
    rise_stb  = half_done && !sck;
    fall_stb  = half_done && sck;
    bit_next  = bit_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (half_done) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      // ws follows the new count so the 63->0 wrap and the ws fall share one edge
      if (fall_stb) begin
        bit_cnt <= bit_next;
        ws      <= bit_next[BIT_CNT_W-1];
      end
    end
  end

endmodule

// File: rtl/i2s_stereo_rx.sv
// I2S master receiver for a pair of MEMS microphones sharing one data line.
// Generates sck/ws, deserialises both 32-bit slots (one-bit I2S delay), keeps
// the top DATA_WIDTH bits of each slot and presents time-aligned sample pairs.
//   clk, reset      : system clock, synchronous active-high reset
//   sd              : serial data from the microphones
//   sck, ws         : I2S bit clock and word select (0 = left, 1 = right)
//   left_data_out   : left sample, two's complement
//   right_data_out  : right sample, two's complement
//   sample_valid    : one-clk pulse when a new pair is presented
// Optional build macro I2S_RX_DC_BLOCK_EN adds a first-order DC blocker per
// channel (time constant DC_SHIFT) and delays sample_valid by one clk.
module i2s_stereo_rx
  import i2s_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned CLK_DIV        = 8,
  parameter int unsigned STARTUP_FRAMES = 4,
  parameter int unsigned DC_SHIFT       = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sd,
  output logic                  sck,
  output logic                  ws,
  output logic [DATA_WIDTH-1:0] left_data_out,
  output logic [DATA_WIDTH-1:0] right_data_out,
  output logic                  sample_valid
);

  if (CLK_DIV < 4 || (CLK_DIV % 2) != 0 || DATA_WIDTH < 2 || DATA_WIDTH > SLOT_BITS ||
      (DATA_WIDTH + DC_SHIFT + 1) > 64) begin : g_param_check
    $error("i2s_stereo_rx: unsupported parameter set");
  end

  localparam int unsigned SU_W = (STARTUP_FRAMES > 0) ? $clog2(STARTUP_FRAMES + 1) : 1;
  localparam logic [BIT_CNT_W-1:0] LEFT_LAST_POS  = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] RIGHT_LAST_POS = BIT_CNT_W'(SLOT_BITS + DATA_WIDTH - 1);

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 rise_stb;
  logic                 fall_stb;

  i2s_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .sck     (sck),
    .ws      (ws),
    .bit_cnt (bit_cnt),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );

  logic [BIT_CNT_W-1:0] pos;
  slot_e                pos_slot;
  logic [4:0]           slot_bit;
  logic                 in_word;
  logic                 left_last;
  logic                 right_last;
  logic [DATA_WIDTH-1:0] left_sr;
  logic [DATA_WIDTH-1:0] right_sr;
  logic [DATA_WIDTH-1:0] left_next;
  logic [DATA_WIDTH-1:0] right_next;
  logic [DATA_WIDTH-1:0] left_hold;
  logic [SU_W-1:0]       startup_cnt;
  logic                  startup_done;
  logic [DATA_WIDTH-1:0] raw_left;
  logic [DATA_WIDTH-1:0] raw_right;
  logic                  raw_valid;

  // One-bit I2S delay: the bit sampled on a rising edge belongs to position b-1.
  always_comb begin
    pos          = bit_cnt - 1'b1;
    pos_slot     = slot_e'(pos[BIT_CNT_W-1]);
    slot_bit     = pos[4:0];
    in_word      = (32'(slot_bit) < DATA_WIDTH);
    left_last    = rise_stb && (pos == LEFT_LAST_POS);
    right_last   = rise_stb && (pos == RIGHT_LAST_POS);
    left_next    = {left_sr[DATA_WIDTH-2:0], sd};
    right_next   = {right_sr[DATA_WIDTH-2:0], sd};
    startup_done = (startup_cnt == SU_W'(STARTUP_FRAMES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      left_sr     <= '0;
      right_sr    <= '0;
      left_hold   <= '0;
      startup_cnt <= '0;
      raw_left    <= '0;
      raw_right   <= '0;
      raw_valid   <= 1'b0;
    end else begin
      raw_valid <= 1'b0;
      if (rise_stb && in_word) begin
        if (pos_slot == SLOT_LEFT) begin
          left_sr <= left_next;
        end else begin
          right_sr <= right_next;
        end
      end
      if (left_last) begin
        left_hold <= left_next;
      end
      // Frame completion: present the pair, or burn one mic wake-up frame.
      if (right_last) begin
        if (startup_done) begin
          raw_left  <= left_hold;
          raw_right <= right_next;
          raw_valid <= 1'b1;
        end else begin
          startup_cnt <= startup_cnt + 1'b1;
        end
      end
    end
  end

`ifdef I2S_RX_DC_BLOCK_EN
  localparam int unsigned ACC_W = DATA_WIDTH + DC_SHIFT + 1;

  logic signed [ACC_W-1:0] acc_l;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] avg_l;
  logic signed [ACC_W-1:0] avg_r;
  logic signed [ACC_W-1:0] diff_l;
  logic signed [ACC_W-1:0] diff_r;
  logic [DATA_WIDTH-1:0]   y_l;
  logic [DATA_WIDTH-1:0]   y_r;

  always_comb begin
    avg_l  = acc_l >>> DC_SHIFT;
    avg_r  = acc_r >>> DC_SHIFT;
    diff_l = ACC_W'(signed'(raw_left)) - avg_l;
    diff_r = ACC_W'(signed'(raw_right)) - avg_r;
    y_l    = DATA_WIDTH'(sat_signed(64'(diff_l), DATA_WIDTH));
    y_r    = DATA_WIDTH'(sat_signed(64'(diff_r), DATA_WIDTH));
  end

  // raw_valid never fires during startup, so the accumulators stay frozen then.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_l          <= '0;
      acc_r          <= '0;
      left_data_out  <= '0;
      right_data_out <= '0;
      sample_valid   <= 1'b0;
    end else begin
      sample_valid <= raw_valid;
      if (raw_valid) begin
        acc_l          <= acc_l + diff_l;
        acc_r          <= acc_r + diff_r;
        left_data_out  <= y_l;
        right_data_out <= y_r;
      end
    end
  end
`else
  always_comb begin
    left_data_out  = raw_left;
    right_data_out = raw_right;
    sample_valid   = raw_valid;
  end
`endif

endmodule
